// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at tail, captures writeback results, answers two
// dependency searches, retires in order at head and flushes on a mispredicted branch.
module reorder_buffer #(
    parameter int ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_is_branch,
    input  logic                 issue_is_store,
    input  logic                 issue_pred_taken,
    input  logic [31:0]          issue_pc,
    output logic [ROB_WIDTH-1:0] free_rob_id,
    output logic                 rob_full,
    input  logic                 wb_valid,
    input  logic [ROB_WIDTH-1:0] wb_rob_id,
    input  logic [31:0]          wb_val,
    input  logic                 wb_taken,
    input  logic [31:0]          wb_target,
    input  logic [ROB_WIDTH-1:0] search_rob_id_1,
    input  logic [ROB_WIDTH-1:0] search_rob_id_2,
    output logic                 search_ready_1,
    output logic                 search_ready_2,
    output logic [31:0]          search_val_1,
    output logic [31:0]          search_val_2,
    output logic                 commit_ready,
    output logic [4:0]           commit_reg_id,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic                 store_commit,
    output logic [ROB_WIDTH-1:0] store_rob_id,
    output logic                 clear,
    output logic [31:0]          clear_pc
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_CNT = {1'b1, {ROB_WIDTH{1'b0}}};

    logic [DEPTH-1:0]       r_busy, r_done, r_is_branch, r_is_store, r_pred_taken, r_taken;
    logic [DEPTH-1:0][4:0]  r_rd;
    logic [DEPTH-1:0][31:0] r_val, r_target, r_pc;
    logic [ROB_WIDTH-1:0]   r_head, r_tail;
    logic [ROB_WIDTH:0]     r_count;

    logic                 r_commit_ready, r_store_commit, r_clear;
    logic [4:0]           r_commit_reg_id;
    logic [31:0]          r_commit_val, r_clear_pc;
    logic [ROB_WIDTH-1:0] r_commit_rob_id, r_store_rob_id;

    logic w_full, w_wb_hit, w_commit, w_mispred, w_issue;

    assign w_full    = (r_count == FULL_CNT);
    assign w_wb_hit  = wb_valid && r_busy[wb_rob_id];
    assign w_commit  = r_busy[r_head] && r_done[r_head];
    assign w_mispred = w_commit && r_is_branch[r_head] && (r_taken[r_head] != r_pred_taken[r_head]);
    // Issue is refused in the cycle the clear pulse is visible to the front end.
    assign w_issue   = issue_valid && !w_full && !r_clear;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy          <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_commit_ready  <= 1'b0;
            r_commit_reg_id <= '0;
            r_commit_val    <= '0;
            r_commit_rob_id <= '0;
            r_store_commit  <= 1'b0;
            r_store_rob_id  <= '0;
            r_clear         <= 1'b0;
            r_clear_pc      <= '0;
        end else if (rdy_in) begin
            r_commit_ready <= w_commit;
            r_store_commit <= w_commit && r_is_store[r_head];
            r_clear        <= w_mispred;
            if (w_commit) begin
                r_commit_reg_id <= r_rd[r_head];
                r_commit_val    <= r_val[r_head];
                r_commit_rob_id <= r_head;
                if (r_is_store[r_head])
                    r_store_rob_id <= r_head;
                if (w_mispred)
                    r_clear_pc <= r_taken[r_head] ? r_target[r_head] : r_pc[r_head] + 32'd4;
            end
            if (w_mispred) begin
                r_busy  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                if (w_issue) begin
                    r_busy[r_tail] <= 1'b1;
                    r_tail         <= r_tail + 1'b1;
                end
                r_count <= r_count + {{ROB_WIDTH{1'b0}}, w_issue} - {{ROB_WIDTH{1'b0}}, w_commit};
            end
        end else begin
            r_commit_ready <= 1'b0;
            r_store_commit <= 1'b0;
            r_clear        <= 1'b0;
        end
    end

    // Payload needs no reset: it is only ever read behind a busy bit.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (w_wb_hit) begin
                r_done[wb_rob_id]   <= 1'b1;
                r_val[wb_rob_id]    <= wb_val;
                r_taken[wb_rob_id]  <= wb_taken;
                r_target[wb_rob_id] <= wb_target;
            end
            if (w_issue) begin
                r_done[r_tail]       <= 1'b0;
                r_rd[r_tail]         <= issue_rd;
                r_is_branch[r_tail]  <= issue_is_branch;
                r_is_store[r_tail]   <= issue_is_store;
                r_pred_taken[r_tail] <= issue_pred_taken;
                r_pc[r_tail]         <= issue_pc;
            end
        end
    end

    logic [1:0][ROB_WIDTH-1:0] w_sid;
    logic [1:0]                w_sbyp, w_srdy;
    logic [1:0][31:0]          w_sval;

    assign w_sid = {search_rob_id_2, search_rob_id_1};

    for (genvar k = 0; k < 2; k++) begin : g_search
        assign w_sbyp[k] = r_busy[w_sid[k]] && wb_valid && (wb_rob_id == w_sid[k]);
        assign w_srdy[k] = w_sbyp[k] || (r_busy[w_sid[k]] && r_done[w_sid[k]]);
        assign w_sval[k] = w_sbyp[k] ? wb_val : (w_srdy[k] ? r_val[w_sid[k]] : 32'd0);
    end

    assign search_ready_1 = w_srdy[0];
    assign search_ready_2 = w_srdy[1];
    assign search_val_1   = w_sval[0];
    assign search_val_2   = w_sval[1];

    assign free_rob_id   = r_tail;
    assign rob_full      = w_full;
    assign commit_ready  = r_commit_ready;
    assign commit_reg_id = r_commit_reg_id;
    assign commit_val    = r_commit_val;
    assign commit_rob_id = r_commit_rob_id;
    assign store_commit  = r_store_commit;
    assign store_rob_id  = r_store_rob_id;
    assign clear         = r_clear;
    assign clear_pc      = r_clear_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic checked every cycle
// against a program-order queue model of the in-flight instructions.
module tb_reorder_buffer;
    logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in;
    logic        issue_valid, issue_is_branch, issue_is_store, issue_pred_taken;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic [2:0]  free_rob_id;
    logic        rob_full;
    logic        wb_valid, wb_taken;
    logic [2:0]  wb_rob_id;
    logic [31:0] wb_val, wb_target;
    logic [2:0]  search_rob_id_1, search_rob_id_2;
    logic        search_ready_1, search_ready_2;
    logic [31:0] search_val_1, search_val_2;
    logic        commit_ready, store_commit, clear;
    logic [4:0]  commit_reg_id;
    logic [31:0] commit_val, clear_pc;
    logic [2:0]  commit_rob_id, store_rob_id;

    reorder_buffer #(.ROB_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .issue_is_store(issue_is_store), .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
        .free_rob_id(free_rob_id), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val), .wb_taken(wb_taken),
        .wb_target(wb_target),
        .search_rob_id_1(search_rob_id_1), .search_rob_id_2(search_rob_id_2),
        .search_ready_1(search_ready_1), .search_ready_2(search_ready_2),
        .search_val_1(search_val_1), .search_val_2(search_val_2),
        .commit_ready(commit_ready), .commit_reg_id(commit_reg_id), .commit_val(commit_val),
        .commit_rob_id(commit_rob_id), .store_commit(store_commit), .store_rob_id(store_rob_id),
        .clear(clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic        br, st, pred, done, tk;
        logic [31:0] pc, val, tgt;
    } ent_t;

    ent_t        q[$];
    int          tail_tag;
    logic        e_cr, e_sc, e_clr;
    logic [4:0]  e_crd;
    logic [31:0] e_cval, e_cpc;
    int          e_crid, e_srid;
    int          checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_search(input int id, output logic rdy, output logic [31:0] val);
        rdy = 1'b0;
        val = 32'd0;
        foreach (q[i]) begin
            if (q[i].tag == id) begin
                if (wb_valid && wb_rob_id == id) begin
                    rdy = 1'b1;
                    val = wb_val;
                end else if (q[i].done) begin
                    rdy = 1'b1;
                    val = q[i].val;
                end
            end
        end
    endfunction

    task automatic idle();
        rdy_in = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_is_branch = 1'b0;
        issue_is_store = 1'b0; issue_pred_taken = 1'b0; issue_pc = '0;
        wb_valid = 1'b0; wb_rob_id = '0; wb_val = '0; wb_taken = 1'b0; wb_target = '0;
        search_rob_id_1 = '0; search_rob_id_2 = '0;
    endtask

    task automatic model_reset();
        q.delete(); tail_tag = 0;
        e_cr = 0; e_sc = 0; e_clr = 0; e_crd = '0; e_cval = '0; e_cpc = '0; e_crid = 0; e_srid = 0;
    endtask

    task automatic reset_check(input string nm);
        chk({nm, "_commit_ready"}, commit_ready, 0);
        chk({nm, "_commit_reg_id"}, commit_reg_id, 0);
        chk({nm, "_commit_val"}, commit_val, 0);
        chk({nm, "_commit_rob_id"}, commit_rob_id, 0);
        chk({nm, "_store_commit"}, store_commit, 0);
        chk({nm, "_store_rob_id"}, store_rob_id, 0);
        chk({nm, "_clear"}, clear, 0);
        chk({nm, "_clear_pc"}, clear_pc, 0);
        chk({nm, "_free_rob_id"}, free_rob_id, 0);
        chk({nm, "_rob_full"}, rob_full, 0);
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic cycle();
        logic        r;
        logic [31:0] v;
        bit          com, full, nclr;
        ent_t        e;
        #1;
        chk("free_rob_id", free_rob_id, tail_tag);
        chk("rob_full", rob_full, q.size() == 8);
        model_search(search_rob_id_1, r, v);
        chk("search_ready_1", search_ready_1, r);
        chk("search_val_1", search_val_1, v);
        model_search(search_rob_id_2, r, v);
        chk("search_ready_2", search_ready_2, r);
        chk("search_val_2", search_val_2, v);
        if (rdy_in) begin
            full = (q.size() == 8);
            com  = (q.size() > 0) && q[0].done;
            nclr = 0;
            e_cr = com;
            e_sc = 0;
            if (com) begin
                e_crd = q[0].rd; e_cval = q[0].val; e_crid = q[0].tag;
                if (q[0].st) begin e_sc = 1; e_srid = q[0].tag; end
                if (q[0].br && q[0].tk != q[0].pred) begin
                    nclr  = 1;
                    e_cpc = q[0].tk ? q[0].tgt : q[0].pc + 32'd4;
                end
            end
            if (wb_valid)
                foreach (q[i])
                    if (q[i].tag == wb_rob_id) begin
                        q[i].done = 1; q[i].val = wb_val; q[i].tk = wb_taken; q[i].tgt = wb_target;
                    end
            if (com) void'(q.pop_front());
            if (issue_valid && !full && !e_clr) begin
                e.tag = tail_tag; e.rd = issue_rd; e.br = issue_is_branch; e.st = issue_is_store;
                e.pred = issue_pred_taken; e.done = 0; e.tk = 0; e.pc = issue_pc; e.val = 0; e.tgt = 0;
                q.push_back(e);
                tail_tag = (tail_tag + 1) % 8;
            end
            if (nclr) begin q.delete(); tail_tag = 0; end
            e_clr = nclr;
        end else begin
            e_cr = 0; e_sc = 0; e_clr = 0;
        end
        @(posedge clk_in);
        #1;
        chk("commit_ready", commit_ready, e_cr);
        chk("store_commit", store_commit, e_sc);
        chk("clear", clear, e_clr);
        if (e_cr) begin
            chk("commit_reg_id", commit_reg_id, e_crd);
            chk("commit_val", commit_val, e_cval);
            chk("commit_rob_id", commit_rob_id, e_crid);
        end
        if (e_sc) chk("store_rob_id", store_rob_id, e_srid);
        if (e_clr) chk("clear_pc", clear_pc, e_cpc);
        @(negedge clk_in);
    endtask

    initial begin
        int k;
        idle();
        model_reset();
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_check("por");
        rst_in = 1'b1;

        // Issue rd=5, write back 0x1234, observe bypass then commit two cycles later.
        issue_valid = 1; issue_rd = 5; issue_pc = 32'h40;
        cycle();
        idle();
        wb_valid = 1; wb_rob_id = 0; wb_val = 32'h1234; search_rob_id_1 = 0;
        #1;
        chk("t2_bypass_ready", search_ready_1, 1);
        chk("t2_bypass_val", search_val_1, 32'h1234);
        cycle();
        idle();
        cycle();
        chk("t2_commit_ready", commit_ready, 1);
        chk("t2_commit_reg_id", commit_reg_id, 5);
        chk("t2_commit_val", commit_val, 32'h1234);
        chk("t2_commit_rob_id", commit_rob_id, 0);

        // Reset asserted between edges must clear the outputs immediately.
        #2 rst_in = 1'b0;
        #1 reset_check("mid");
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;

        // Fill to full with stores at tags 0 and 1, then wrap-around.
        for (int i = 0; i < 8; i++) begin
            idle();
            issue_valid = 1; issue_is_store = (i < 2); issue_rd = (i < 2) ? 5'd0 : 5'(i + 1);
            issue_pc = 32'h100 + 32'(4 * i);
            cycle();
        end
        idle();
        issue_valid = 1; issue_rd = 9;
        #1;
        chk("t3_full", rob_full, 1);
        chk("t3_free_full", free_rob_id, 0);
        cycle();
        chk("t3_ninth_ignored", free_rob_id, 0);
        idle();
        wb_valid = 1; wb_rob_id = 0; wb_val = 32'hAAAA;
        cycle();
        idle();
        issue_valid = 1; issue_rd = 11; wb_valid = 1; wb_rob_id = 1; wb_val = 32'hBBBB;
        cycle();
        chk("t6_store_commit0", store_commit, 1);
        chk("t6_store_rob_id0", store_rob_id, 0);
        chk("t6_commit_reg0", commit_reg_id, 0);
        chk("t6_free_after_full_issue", free_rob_id, 0);
        idle();
        issue_valid = 1; issue_rd = 20; wb_valid = 1; wb_rob_id = 2; wb_val = 32'hCCCC;
        cycle();
        chk("t6_store_commit1", store_commit, 1);
        chk("t6_store_rob_id1", store_rob_id, 1);
        chk("t6_count_same", rob_full, 0);
        chk("t3_wrap_tag", free_rob_id, 1);

        idle();
        rst_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;

        // Branch at tag 2 predicted not-taken, resolves taken; completions out of order.
        for (int i = 0; i < 8; i++) begin
            idle();
            issue_valid = 1; issue_is_branch = (i == 2); issue_rd = (i == 2) ? 5'd0 : 5'(i + 1);
            issue_pc = 32'h80 + 32'(4 * i);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            k = (i == 4) ? 0 : i + 1;
            wb_valid = 1; wb_rob_id = 3'(k); wb_val = 32'h500 + 32'(k);
            wb_taken = (k == 2); wb_target = (k == 2) ? 32'h100 : 32'h0;
            cycle();
            chk("t4_no_early_commit", commit_ready, 0);
        end
        idle();
        cycle();
        chk("t4_commit_first", commit_ready, 1);
        chk("t4_commit_id0", commit_rob_id, 0);
        cycle();
        chk("t4_commit_id1", commit_rob_id, 1);
        cycle();
        chk("t5_clear", clear, 1);
        chk("t5_clear_pc", clear_pc, 32'h100);
        chk("t5_commit_id2", commit_rob_id, 2);
        chk("t5_full_after", rob_full, 0);
        chk("t5_free_after", free_rob_id, 0);
        search_rob_id_1 = 3; search_rob_id_2 = 4;
        #1;
        chk("t5_search3", search_ready_1, 0);
        chk("t5_search4", search_ready_2, 0);
        search_rob_id_1 = 5; search_rob_id_2 = 6;
        #1;
        chk("t5_search5", search_ready_1, 0);
        chk("t5_search6", search_ready_2, 0);
        search_rob_id_1 = 7;
        issue_valid = 1; issue_rd = 3;
        #1;
        chk("t5_search7", search_ready_1, 0);
        cycle();
        chk("t5_issue_during_clear", free_rob_id, 0);

        // Random traffic against the queue model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rdy_in           = ($urandom % 10) != 0;
            issue_valid      = ($urandom % 10) < 6;
            issue_is_branch  = ($urandom % 5) == 0;
            issue_is_store   = !issue_is_branch && (($urandom % 5) == 0);
            issue_rd         = (issue_is_branch || issue_is_store) ? 5'd0 : 5'($urandom % 32);
            issue_pred_taken = 1'($urandom);
            issue_pc         = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            wb_valid         = ($urandom % 10) < 6;
            wb_val           = $urandom;
            wb_target        = $urandom;
            if (q.size() > 0 && ($urandom % 4) != 0) begin
                k = $urandom % q.size();
                wb_rob_id = 3'(q[k].tag);
                wb_taken  = (($urandom % 6) == 0) ? !q[k].pred : q[k].pred;
            end else begin
                wb_rob_id = 3'($urandom % 8);
                wb_taken  = 1'($urandom);
            end
            search_rob_id_1 = 3'($urandom % 8);
            search_rob_id_2 = 3'($urandom % 8);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
